// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per cycle, with valid/ready handshakes on both sides.
module bin_to_bcd_seq #(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter int LZ_BLANK = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic longint unsigned max_for_digits(input int d);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < d; i++) v = v * 10;
        return v - 1;
    endfunction

    localparam longint unsigned MAX_VAL = max_for_digits(DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic               started;
    logic [BIN_W-1:0]   bin_reg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   final_bcd;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_reg;
    logic               seen;
    logic               accept;

    // Next-state logic; in_ready stays low until the first edge after reset.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = started;
                if (in_valid && started) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    // Result formatting: saturate on overflow, otherwise optional leading-zero blanking.
    always_comb begin
        final_bcd = acc;
        seen      = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (acc[4*d +: 4] != 4'd0) seen = 1'b1;
            if ((LZ_BLANK != 0) && !seen) final_bcd[4*d +: 4] = 4'hF;
        end
        if (ovf_reg) final_bcd = {DIGITS{4'h9}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
        end
    end

    // The extra cycle at cnt==0 registers the formatted result before DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg  <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_reg  <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                bin_reg <= bin_in;
                ovf_reg <= (64'(bin_in) > MAX_VAL);
                acc     <= '0;
                cnt     <= CNT_W'(BIN_W);
            end else if (state == SHIFT) begin
                if (cnt != '0) begin
                    acc     <= ACC_W'({acc_adj, bin_reg[BIN_W-1]});
                    bin_reg <= bin_reg << 1;
                    cnt     <= cnt - CNT_W'(1);
                end else begin
                    bcd_out  <= final_bcd;
                    overflow <= ovf_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: three converter instances (default, leading-zero blanking,
// two digits) share stimulus; a monitor checks each result against hand values.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  bin_in;
    logic        out_ready;

    logic        in_ready, out_valid, overflow;
    logic [11:0] bcd_out;
    logic        in_ready_lz, out_valid_lz, overflow_lz;
    logic [11:0] bcd_out_lz;
    logic        in_ready_d2, out_valid_d2, overflow_d2;
    logic [7:0]  bcd_out_d2;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .LZ_BLANK(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .overflow(overflow)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .LZ_BLANK(1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_lz),
        .bin_in(bin_in), .out_valid(out_valid_lz), .out_ready(out_ready),
        .bcd_out(bcd_out_lz), .overflow(overflow_lz)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2), .LZ_BLANK(0)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d2),
        .bin_in(bin_in), .out_valid(out_valid_d2), .out_ready(out_ready),
        .bcd_out(bcd_out_d2), .overflow(overflow_d2)
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] def_bcd;
        logic [11:0] lz_bcd;
        logic [7:0]  d2_bcd;
        logic        d2_ovf;
    } vec_t;

    typedef struct {
        vec_t v;
        int   accept_edge;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input bit push, input bit check_gap);
        int waited;
        int gap;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        bin_in   = vecs[idx].bin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bin_in   = 8'($urandom);
        if (push) sb.push_back('{vecs[idx], edge_cnt});
        if (check_gap) begin
            gap = 0;
            @(negedge clk);
            while (!in_ready && gap < 100) begin
                gap++;
                @(negedge clk);
            end
            checkOutput("ready_gap", 64'(gap), 64'd10);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, contents at handshake.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (sb.size() == 0) checkOutput("spurious_valid", 64'd1, 64'd0);
                    else checkOutput("latency", 64'(edge_cnt - sb[0].accept_edge), 64'd9);
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("def_result", {overflow, bcd_out}, {1'b0, e.v.def_bcd});
                    checkOutput("lz_result", {overflow_lz, bcd_out_lz}, {1'b0, e.v.lz_bcd});
                    checkOutput("d2_result", {overflow_d2, bcd_out_d2}, {e.v.d2_ovf, e.v.d2_bcd});
                    checkOutput("valid_sync", {out_valid_lz, out_valid_d2}, 2'b11);
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        int w;
        int seen_valid;
        vecs[0] = '{8'd255, 12'h255, 12'h255, 8'h99, 1'b1};
        vecs[1] = '{8'd59,  12'h059, 12'hF59, 8'h59, 1'b0};
        vecs[2] = '{8'd0,   12'h000, 12'hFF0, 8'h00, 1'b0};
        vecs[3] = '{8'd7,   12'h007, 12'hFF7, 8'h07, 1'b0};
        vecs[4] = '{8'd100, 12'h100, 12'h100, 8'h99, 1'b1};
        vecs[5] = '{8'd123, 12'h123, 12'h123, 8'h99, 1'b1};
        vecs[6] = '{8'd99,  12'h099, 12'hF99, 8'h99, 1'b0};
        vecs[7] = '{8'd42,  12'h042, 12'hF42, 8'h42, 1'b0};
        vecs[8] = '{8'd9,   12'h009, 12'hFF9, 8'h09, 1'b0};
        vecs[9] = '{8'd200, 12'h200, 12'h200, 8'h99, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bin_in    = 8'd0;
        out_ready = 1'b1;
        #1;
        checkOutput("reset_outputs", {in_ready, out_valid, overflow, bcd_out}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ready_held", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

        $display("[TB] directed vectors, out_ready held high");
        foreach (vecs[i]) begin
            if (i != 5 && i != 7 && i != 9) applyStimulus(i, 1'b1, 1'b1);
        end

        $display("[TB] stalled consumer with in_valid/bin_in toggling");
        out_ready = 1'b0;
        applyStimulus(5, 1'b1, 1'b0);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("stall_reach_done", 64'(out_valid), 64'd1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("stall_hold", {out_valid, in_ready, overflow, bcd_out}, {2'b10, 1'b0, vecs[5].def_bcd});
            checkOutput("stall_hold_d2", {overflow_d2, bcd_out_d2}, {1'b1, 8'h99});
            in_valid = 1'($urandom);
            bin_in   = 8'($urandom);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 3) begin
            @(negedge clk);
            w++;
        end
        checkOutput("ready_return", 64'(in_ready), 64'd1);

        $display("[TB] reset during SHIFT");
        applyStimulus(9, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_outputs", {in_ready, out_valid, overflow, bcd_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        checkOutput("no_valid_after_abort", 64'(seen_valid), 64'd0);
        applyStimulus(7, 1'b1, 1'b1);

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("scoreboard_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL have parameter BIN_W, default 8: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: BCD output digit count, legal range 1..10.
REQ-003 SHALL have parameter LZ_BLANK, default 0: 1 = replace leading-zero digits with 4'hF (blank code).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  bin_in holds a value to convert.
REQ-007 SHALL have port in_ready  output  1  block can accept a new value.
REQ-008 SHALL have port bin_in  input  BIN_W  unsigned binary value.
REQ-009 SHALL have port out_valid  output  1  bcd_out/overflow hold a finished result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port bcd_out  output  4*DIGITS  packed BCD, digit 0 (ones) in [3:0], most significant digit in top nibble.
REQ-012 SHALL have port overflow  output  1  value exceeded 10^DIGITS-1.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 IDLE: SHALL accept on rising edge with in_valid=1; capture bin_in and the overflow compare, clear the BCD accumulator, load the bit counter with BIN_W, and go to SHIFT.
REQ-015 SHALL sample bin_in only at the accept edge; later changes to bin_in SHALL NOT affect the result.
REQ-016 SHIFT: each cycle SHALL add 3 to every accumulator digit >=5, then shift {accumulator, binary} left by 1 bit and decrement the counter.
REQ-017 SHALL process one input bit per cycle, MSB first; after the BIN_W-th shift it SHALL go to DONE.
REQ-018 SHALL assert out_valid exactly BIN_W+1 rising edges after the accept edge.
REQ-019 DONE: SHALL hold bcd_out and overflow stable while out_ready=0.
REQ-020 DONE: on a rising edge with out_ready=1 it SHALL go to IDLE; in_ready rises the next cycle, and there is no same-cycle re-accept.
REQ-021 Throughput: at most one conversion per BIN_W+2 cycles.
REQ-022 in_valid outside IDLE SHALL be ignored, with no queuing.
REQ-023 Overflow: if bin_in > 10^DIGITS-1 (constant computed at elaboration), overflow=1 and bcd_out SHALL be all digits 4'h9; otherwise overflow=0.
REQ-024 LZ_BLANK=1: every digit above the most significant nonzero digit SHALL read 4'hF; digit 0 SHALL never be blanked; no blanking when overflow=1.
REQ-025 Arithmetic: internal accumulator width 4*DIGITS; the bit counter SHALL be sized for the value BIN_W.
REQ-026 Bits shifted out of the top digit SHALL be discarded, since correctness relies on REQ-023.
REQ-027 bcd_out and overflow SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, in_ready=0, out_valid=0, bcd_out=0, overflow=0, and counter=0, regardless of clock.
REQ-029 in_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-030 Reset during SHIFT or DONE SHALL abort the conversion, with no result emitted after release.

Verification
REQ-031 Defaults, bin_in=8'd255, out_ready=1 -> out_valid 9 edges after accept, bcd_out=12'h255, overflow=0.
REQ-032 Defaults, bin_in=8'd59, then bin_in=8'd0 back-to-back -> results 12'h059 then 12'h000, with in_ready low for 10 cycles between accepts.
REQ-033 LZ_BLANK=1, bin_in=8'd7 -> 12'hFF7; bin_in=8'd0 -> 12'hFF0; bin_in=8'd100 -> 12'h100.
REQ-034 DIGITS=2, bin_in=8'd123 -> bcd_out=8'h99, overflow=1; bin_in=8'd99 -> 8'h99, overflow=0.
REQ-035 out_ready=0 for 20 cycles in DONE while bin_in and in_valid toggle -> outputs frozen, in_ready=0, then handshake completes and in_ready returns.
REQ-036 rst_n pulsed low mid-SHIFT (cycle 4) -> all outputs 0 asynchronously, no out_valid afterwards, and the next accepted 8'd42 yields 12'h042.
